boot_loader: RTL
================

Name: boot_loader

Overview:
Upstream boot stage for the instruction memory. After reset it accepts a length-prefixed program image from the BIOS word source over a valid/ready handshake and writes each word into instruction memory at consecutive addresses. It then checks an XOR checksum and releases the core by dropping `on_bios` and the register-file reset. This block replaces the ad hoc delay-based `onBios` sequencing in the top level with a deterministic handshake-driven load.

Parameters:
ADDR_WIDTH, 32, width of instruction-memory address
DATA_WIDTH, 32, width of program words
BASE_ADDRESS, 0, address of first program word
MAX_WORDS, 1024, largest accepted program length
TIMEOUT_CYCLES, 1000, idle cycles waiting for data_valid before error
RELEASE_CYCLES, 2, cycles core_reset stays high after a successful check

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high
data_in  in  DATA_WIDTH  word from BIOS source
data_valid  in  1  data_in holds a word
data_ready  out  1  loader accepts data_in this cycle
mem_address  out  ADDR_WIDTH  instruction-memory address
mem_data  out  DATA_WIDTH  instruction-memory write data
mem_we  out  1  write enable, active-high
mem_oe  out  1  output enable, 0 during load, 1 in RUN
mem_cs  out  1  chip select, active-low, held 0
on_bios  out  1  high until RUN
core_reset  out  1  drives register-file reset
word_count  out  ADDR_WIDTH  program words written so far
done  out  1  load succeeded
error  out  1  sticky load failure

Behaviour:
- Clock and reset: one clock domain, `clock`. `reset` is asynchronous and active-high.
- Reset values: data_ready=0, mem_we=0, mem_oe=0, mem_cs=0, mem_address=BASE_ADDRESS, mem_data=0, on_bios=1, core_reset=1, word_count=0, done=0, error=0. The FSM goes to IDLE, and the checksum and timeout counters clear.
- States: IDLE, LEN, LOAD, WRITE, CHECK, RELEASE, RUN, ERROR.
- IDLE: lasts one cycle after reset deassert, then goes to LEN.
- Handshake: a transfer occurs on a rising edge where data_valid && data_ready. data_ready=1 only in LEN, LOAD and CHECK. The source must hold data_in stable while data_valid=1 and data_ready=0.
- LEN: the accepted word is N.
  - N==0 or N>MAX_WORDS -> ERROR.
  - Otherwise latch N, then LOAD.
- LOAD: accept a word, latch it into mem_data, XOR it into the checksum, then WRITE.
- WRITE: exactly one cycle.
  - mem_we=1, mem_address=BASE_ADDRESS+word_count, data_ready=0.
  - On exit, word_count increments.
  - If the new word_count==N -> CHECK, else -> LOAD.
  - Throughput is at most one word per 2 cycles.
- CHECK: accept one word.
  - Equal to the running XOR -> RELEASE.
  - Otherwise -> ERROR.
- Timeout: in LEN, LOAD or CHECK, count consecutive cycles with data_valid=0. Reaching TIMEOUT_CYCLES -> ERROR. Any cycle with data_valid=1 clears the counter.
- RELEASE: hold core_reset=1 for RELEASE_CYCLES, then go to RUN.
- RUN (terminal until reset): on_bios=0, core_reset=0, mem_oe=1, done=1, data_ready=0, mem_we=0.
- ERROR (terminal until reset): error=1, on_bios=1, core_reset=1, data_ready=0, mem_we=0, done=0.
- mem_we is never high outside WRITE.
- Address arithmetic is modulo 2^ADDR_WIDTH, with no wrap check beyond the MAX_WORDS limit.
- Reset mid-load: everything returns to reset values immediately. Memory contents already written are not cleared.
- data_valid asserted in states where data_ready=0 is ignored and not consumed.

Decomposition:
- Shared package `boot_pkg`:
  - state enum, with encodings IDLE=0 … ERROR=7
  - default widths
  - checksum-seed constant (0)
- One sub-module, `boot_timeout`: a resettable saturating counter with clear, enable and expire ports. Everything else stays in boot_loader.

Test Plan:
- Nominal load: stream N=3, words 0x11, 0x22, 0x44, checksum 0x77 with data_valid always 1.
  - Three mem_we pulses at addresses 0, 1, 2 with those data.
  - word_count=3.
  - core_reset falls 2 cycles after the checksum is accepted, on_bios=0, done=1.
- Backpressure and gaps: same image with data_valid toggled randomly but gaps < TIMEOUT_CYCLES.
  - Identical memory writes, done=1.
  - No word is consumed when data_ready=0.
- Bad length: N=0, then separately N=MAX_WORDS+1.
  - error=1 next cycle, no mem_we ever, on_bios stays 1.
- Bad checksum: N=2, words 0x5, 0x3, checksum 0x7.
  - Two writes occur, then error=1, done=0, core_reset stays 1.
- Timeout: N=4, send 2 words, then hold data_valid=0.
  - error=1 exactly TIMEOUT_CYCLES cycles after the last transfer.
- Reset mid-load: assert reset asynchronously during WRITE of word 1.
  - All outputs take reset values without waiting for a clock edge.
  - A subsequent full image loads correctly from address 0.

Source files
------------

// File: rtl/boot_pkg.sv
// Shared definitions for the boot loader.
// Contents:
//   bootState_t   - boot FSM states, IDLE=0 through ERROR=7
//   DEFAULT_*     - default address and data widths
//   CHECKSUM_SEED - starting value of the running XOR checksum
package boot_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LEN     = 3'd1,
        LOAD    = 3'd2,
        WRITE   = 3'd3,
        CHECK   = 3'd4,
        RELEASE = 3'd5,
        RUN     = 3'd6,
        ERROR   = 3'd7
    } bootState_t;

    localparam int DEFAULT_ADDR_WIDTH = 32;
    localparam int DEFAULT_DATA_WIDTH = 32;

    localparam logic [DEFAULT_DATA_WIDTH-1:0] CHECKSUM_SEED = '0;

endpackage

// File: rtl/boot_timeout.sv
// Saturating idle-cycle counter used to detect a stalled BIOS word source.
// Ports:
//   clock  - system clock, rising edge
//   reset  - asynchronous, active-high
//   clear  - restart the count from zero (has priority over enable)
//   enable - this cycle counts as an idle cycle
//   expire - the current enabled cycle is the LIMIT-th idle cycle in a row
module boot_timeout #(
    parameter int LIMIT = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int CW = $clog2(LIMIT + 1);
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] count;

    // The count holds at LAST so expire stays asserted for as long as the
    // source remains idle.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST)) begin
            count <= count + 1'b1;
        end
    end

    // Asserted during the cycle that completes the LIMIT-th idle cycle, so
    // the FSM can leave on that same edge.
    assign expire = enable && (count == LAST);

endmodule

// File: rtl/boot_loader.sv
// Boot loader: receives a length-prefixed program image from the BIOS word
// source over a valid/ready handshake, writes it into instruction memory at
// consecutive addresses, verifies an XOR checksum and then releases the core.
// Ports:
//   clock, reset           - system clock, asynchronous active-high reset
//   data_in, data_valid    - word from the BIOS source and its valid flag
//   data_ready             - loader accepts data_in this cycle
//   mem_address, mem_data  - instruction-memory write address and data
//   mem_we, mem_oe, mem_cs - write enable, output enable, chip select (low)
//   on_bios, core_reset    - high until the core is released
//   word_count             - program words written so far
//   done, error            - load succeeded / sticky load failure
module boot_loader
    import boot_pkg::*;
#(
    parameter int                    ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int                    DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDRESS   = '0,
    parameter int                    MAX_WORDS      = 1024,
    parameter int                    TIMEOUT_CYCLES = 1000,
    parameter int                    RELEASE_CYCLES = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  data_ready,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic                  mem_cs,
    output logic                  on_bios,
    output logic                  core_reset,
    output logic [ADDR_WIDTH-1:0] word_count,
    output logic                  done,
    output logic                  error
);

    localparam int RW = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;
    localparam logic [RW-1:0]         RELEASE_LAST = RW'(RELEASE_CYCLES - 1);
    localparam logic [DATA_WIDTH-1:0] MAX_LEN      = DATA_WIDTH'(MAX_WORDS);

    bootState_t            state;
    bootState_t            nextState;
    logic [ADDR_WIDTH-1:0] wordCount;
    logic [ADDR_WIDTH-1:0] programLength;
    logic [DATA_WIDTH-1:0] checksum;
    logic [DATA_WIDTH-1:0] memData;
    logic [RW-1:0]         releaseCount;
    logic                  waiting;
    logic                  transfer;
    logic                  lastWord;
    logic                  timeoutActive;
    logic                  timeoutExpire;

    assign waiting  = (state == LEN) || (state == LOAD) || (state == CHECK);
    assign transfer = waiting && data_valid;
    assign lastWord = (wordCount + 1'b1) == programLength;

    // Idle time is measured from the last accepted word, so the single WRITE
    // cycle between two data words counts towards the timeout as well.
    assign timeoutActive = waiting || (state == WRITE);

    boot_timeout #(
        .LIMIT(TIMEOUT_CYCLES)
    ) uTimeout (
        .clock (clock),
        .reset (reset),
        .clear (data_valid || !timeoutActive),
        .enable(timeoutActive && !data_valid),
        .expire(timeoutExpire)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and state-decoded outputs. All outputs are decoded from the
    // state so an asynchronous reset drives them to their idle values at once.
    always_comb begin
        nextState  = state;
        data_ready = 1'b0;
        mem_we     = 1'b0;
        mem_oe     = 1'b0;
        on_bios    = 1'b1;
        core_reset = 1'b1;
        done       = 1'b0;
        error      = 1'b0;
        case (state)
            IDLE: begin
                nextState = LEN;
            end
            LEN: begin
                data_ready = 1'b1;
                if (timeoutExpire) begin
                    nextState = ERROR;
                end else if (transfer) begin
                    if ((data_in == '0) || (data_in > MAX_LEN)) begin
                        nextState = ERROR;
                    end else begin
                        nextState = LOAD;
                    end
                end
            end
            LOAD: begin
                data_ready = 1'b1;
                if (timeoutExpire) begin
                    nextState = ERROR;
                end else if (transfer) begin
                    nextState = WRITE;
                end
            end
            WRITE: begin
                mem_we    = 1'b1;
                nextState = lastWord ? CHECK : LOAD;
            end
            CHECK: begin
                data_ready = 1'b1;
                if (timeoutExpire) begin
                    nextState = ERROR;
                end else if (transfer) begin
                    nextState = (data_in == checksum) ? RELEASE : ERROR;
                end
            end
            RELEASE: begin
                if (releaseCount == RELEASE_LAST) begin
                    nextState = RUN;
                end
            end
            RUN: begin
                mem_oe     = 1'b1;
                on_bios    = 1'b0;
                core_reset = 1'b0;
                done       = 1'b1;
            end
            ERROR: begin
                error = 1'b1;
            end
            default: begin
                nextState = ERROR;
            end
        endcase
    end

    // Datapath: program length, write data, running checksum, word and
    // release counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wordCount     <= '0;
            programLength <= '0;
            checksum      <= DATA_WIDTH'(CHECKSUM_SEED);
            memData       <= '0;
            releaseCount  <= '0;
        end else begin
            if ((state == LEN) && transfer) begin
                programLength <= ADDR_WIDTH'(data_in);
            end
            if ((state == LOAD) && transfer) begin
                memData  <= data_in;
                checksum <= checksum ^ data_in;
            end
            if (state == WRITE) begin
                wordCount <= wordCount + 1'b1;
            end
            if (state == RELEASE) begin
                releaseCount <= releaseCount + 1'b1;
            end else begin
                releaseCount <= '0;
            end
        end
    end

    assign mem_cs      = 1'b0;
    assign mem_address = BASE_ADDRESS + wordCount;
    assign mem_data    = memData;
    assign word_count  = wordCount;

endmodule
